fp_minmax_reduce: RTL and testbench
===================================

# fp_minmax_reduce

Streaming reduction controller for the FPU's min/max datapath. It accepts a packet of IEEE-754 single-precision operands over a valid/ready handshake and sequences one shared comparator across the packet, one element per cycle. It then returns the packet minimum or maximum and the element count. It sits between an operand source (load unit or vector lane sequencer) and the FPU result bus.

## Interface
Parameters:
- CNT_W, 16, width of the element counter; the count saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  32  fp32 operand.
- in_last  in  1  final operand of the packet.
- in_op  in  1  0 = min, 1 = max. Sampled only with the first operand of a packet.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  reduced fp32 value.
- out_count  out  CNT_W  number of operands in the packet (saturating).

## Operation
- Ordering is fixed by fp_cmp:
  - Any sign-0 value is greater than any sign-1 value, so -0 (0x80000000) < +0 (0x00000000).
  - Same sign: compare {exp, mantissa} as unsigned. Positive: larger magnitude is greater. Negative: larger magnitude is lesser.
  - Equal bit patterns are equal.
  - No NaN/Inf special-casing: exp=0xFF orders as largest magnitude.
- min selects the lesser value and max the greater. On a tie the accumulator is kept.
- The FSM has three states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=1.
  - On handshake: acc<=in_data, op_q<=in_op, cnt<=1.
  - Next state is HOLD if in_last, else ACCUM.
- ACCUM:
  - in_ready=1.
  - On handshake: acc<=select(op_q, acc, in_data), cnt<=cnt+1 (saturating).
  - Next state is HOLD if in_last.
  - in_op is ignored in this state.
- HOLD:
  - in_ready=0, out_valid=1, out_data=acc, out_count=cnt.
  - On out_ready: next state is IDLE.
  - Outputs stay stable until accepted.
- A cycle with in_valid=0 leaves the state and registers unchanged.
- Reset values:
  - state=IDLE, acc=0, cnt=0, op_q=0.
  - out_valid=0, out_data=0, out_count=0.
  - in_ready=0 while rst_n=0.

## Timing
- Throughput is one operand per cycle while in IDLE or ACCUM.
- out_valid rises on the clock edge that accepts the in_last operand, so it is visible the next cycle. Latency is 1 cycle from the last handshake.
- The minimum packet-to-packet gap is 1 cycle: HOLD lasts at least one cycle, even with out_ready held high.
- A result is never dropped. in_ready stays 0 until the result handshake completes.
- A single-operand packet (in_last on the first beat) goes IDLE→HOLD and outputs in_data unchanged, with count 1.
- Reset mid-packet or mid-HOLD returns to the reset values on the next edge. The partial result is discarded, and the source must restart the packet.
- out_ready while not in HOLD is ignored.
- out_* are driven from registers and state only. There is no combinational path from in_* to out_*.
- in_ready depends only on state and rst_n.

## Structure
- Package fp_pkg holds:
  - typedef enum {IDLE, ACCUM, HOLD} for the FSM state;
  - typedef enum {OP_MIN=0, OP_MAX=1} for the operation;
  - constant FP_W=32;
  - sign/exp/mantissa field localparams (bit 31, [30:23], [22:0]).
- Sub-module fp_cmp is purely combinational. It takes a, b and returns a_lt_b and eq under the ordering above. It is instantiated once and shared by all elements.
- The top module contains the FSM, acc, cnt, op_q and the select mux.

## Test plan
- Max over four operands:
  - Stimulus: in_op=1, stream 0x3F800000 (1.0), 0xC0400000 (-3.0), 0x40000000 (2.0), 0x3F000000 (0.5, last), no stalls.
  - Required: out_data=0x40000000 and out_count=4, one cycle after the last handshake.
- Min over the same stream with in_op=0:
  - Required: out_data=0xC0400000, count 4.
- Signed zeros:
  - min of {0x00000000, 0x80000000} → 0x80000000.
  - max of the same → 0x00000000.
- Single operand, backpressure, in_op ignored:
  - Stimulus: single operand 0xBF800000 with in_last; out_ready held 0 for 5 cycles; then a new in_valid beat with a different in_op.
  - Required: out_valid held with stable data 0xBF800000 and count 1; in_ready=0 throughout.
  - After the out_ready handshake: IDLE next cycle.
  - Between packets, the new in_op takes effect only on the first beat.
- Reset mid-packet:
  - Stimulus: after 2 operands, rst_n=0 for 1 cycle, then a packet {0x40400000 (last)} with max.
  - Required: all outputs at reset values during reset; result 0x40400000 with count 1, with no contamination from the aborted packet.
- Counter saturation:
  - Stimulus: CNT_W=2, 6-operand packet.
  - Required: out_count=3 and out_data correct.

Source files
------------

// File: rtl/fp_minmax_reduce_pkg.sv
// Shared types and field layout for the fp32 min/max reduction block.
package fp_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MIN = 1'b0,
    OP_MAX = 1'b1
  } op_t;

endpackage

// File: rtl/fp_minmax_reduce_cmp.sv
// Combinational fp32 total-order comparator: sign first, then {exp, mantissa}
// magnitude. No NaN/Inf special-casing; -0 orders below +0.
module fp_cmp
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            a_lt_b,
  output logic            eq
);

  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [EXP_MSB:MAN_LSB] w_mag_a;
  logic [EXP_MSB:MAN_LSB] w_mag_b;

  assign w_sign_a = a[SIGN_BIT];
  assign w_sign_b = b[SIGN_BIT];
  assign w_mag_a  = a[EXP_MSB:MAN_LSB];
  assign w_mag_b  = b[EXP_MSB:MAN_LSB];

  always_comb begin
    eq     = (a == b);
    a_lt_b = 1'b0;
    if (w_sign_a != w_sign_b) begin
      a_lt_b = w_sign_a;
    end else if (w_sign_a) begin
      // Both negative: the larger magnitude is the lesser value.
      a_lt_b = (w_mag_a > w_mag_b);
    end else begin
      a_lt_b = (w_mag_a < w_mag_b);
    end
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming min/max reduction over an fp32 packet with one shared comparator;
// the result is held in HOLD until the consumer accepts it.
module fp_minmax_reduce
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both 1; valid never waits on ready, and the result is held
  // stable in HOLD until out_ready completes the transfer.

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next_state;
  logic [FP_W-1:0]   r_acc;
  logic [CNT_W-1:0]  r_cnt;
  op_t               r_op;
  logic              w_in_fire;
  logic              w_in_lt_acc;
  logic              w_in_eq_acc;
  logic              w_take_in;

  fp_cmp u_cmp (
    .a      (in_data),
    .b      (r_acc),
    .a_lt_b (w_in_lt_acc),
    .eq     (w_in_eq_acc)
  );

  assign w_in_fire = in_valid & in_ready;
  // Ties keep the accumulator, so max only takes strictly greater inputs.
  assign w_take_in = (r_op == OP_MIN) ? w_in_lt_acc : ~(w_in_lt_acc | w_in_eq_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_next_state = in_last ? HOLD : ACCUM;
      ACCUM:   if (w_in_fire && in_last) w_next_state = HOLD;
      HOLD:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (r_state != HOLD);
    out_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_op  <= OP_MIN;
    end else if (w_in_fire) begin
      if (r_state == IDLE) begin
        r_acc <= in_data;
        r_op  <= op_t'(in_op);
        r_cnt <= CNT_W'(1);
      end else begin
        if (w_take_in) r_acc <= in_data;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed bench for fp_minmax_reduce: a CNT_W=16 instance and a CNT_W=2
// instance share the same stimulus; results are checked with immediate asserts.
module tb_fp_minmax_reduce;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic [1:0]  dbg_state;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_count;
  logic [1:0]  s_dbg_state;

  int n_checks;
  int n_errors;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_minmax_reduce #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  fp_minmax_reduce #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_op     (in_op),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_count (s_out_count),
    .dbg_state (s_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present one beat and hold it until accepted (bounded wait)
  task automatic beat(input logic [31:0] d, input logic last, input logic op);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_op    = op;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("beat_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // check held result one cycle after the last beat, then accept it
  task automatic take_result(input string tag, input logic [31:0] exp_d, input logic [15:0] exp_c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_count"}, 32'(out_count), 32'(exp_c));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_op     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // max over {1.0, -3.0, 2.0, 0.5}
    beat(32'h3F800000, 1'b0, 1'b1);
    beat(32'hC0400000, 1'b0, 1'b1);
    beat(32'h40000000, 1'b0, 1'b1);
    beat(32'h3F000000, 1'b1, 1'b1);
    take_result("max4", 32'h40000000, 16'd4);

    // min over the same stream
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'hC0400000, 1'b0, 1'b0);
    beat(32'h40000000, 1'b0, 1'b0);
    beat(32'h3F000000, 1'b1, 1'b0);
    take_result("min4", 32'hC0400000, 16'd4);

    // signed zeros
    beat(32'h00000000, 1'b0, 1'b0);
    beat(32'h80000000, 1'b1, 1'b0);
    take_result("min_zero", 32'h80000000, 16'd2);
    beat(32'h00000000, 1'b0, 1'b1);
    beat(32'h80000000, 1'b1, 1'b1);
    take_result("max_zero", 32'h00000000, 16'd2);

    // exp=0xFF orders as largest magnitude; tie keeps accumulator
    beat(32'h7F7FFFFF, 1'b0, 1'b1);
    beat(32'h7F800000, 1'b0, 1'b1);
    beat(32'h7F800000, 1'b1, 1'b1);
    take_result("max_inf", 32'h7F800000, 16'd3);
    beat(32'hBF800000, 1'b0, 1'b0);
    beat(32'hC0400000, 1'b1, 1'b0);
    take_result("min_neg", 32'hC0400000, 16'd2);

    // single operand with backpressure; a new beat waits during HOLD
    beat(32'hBF800000, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    in_last  = 1'b0;
    in_op    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, 32'hBF800000);
      chk("bp_count", 32'(out_count), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_state", 32'(dbg_state), 32'(ST_HOLD));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("bp_valid_low", 32'(out_valid), 32'd0);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // second beat flips in_op to min; it must be ignored mid-packet
    in_data = 32'h40000000;
    in_op   = 1'b0;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result("op_first_beat", 32'h40000000, 16'd2);

    // reset mid-packet
    beat(32'h40800000, 1'b0, 1'b1);
    beat(32'hC0000000, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_comb", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    beat(32'h40400000, 1'b1, 1'b1);
    take_result("after_rst", 32'h40400000, 16'd1);

    // six operands: CNT_W=2 instance saturates at 3
    beat(32'h3F800000, 1'b0, 1'b1);
    beat(32'h3F000000, 1'b0, 1'b1);
    beat(32'h40400000, 1'b0, 1'b1);
    beat(32'hBF800000, 1'b0, 1'b1);
    beat(32'h40000000, 1'b0, 1'b1);
    beat(32'h3F000000, 1'b1, 1'b1);
    chk("sat_valid", 32'(s_out_valid), 32'd1);
    chk("sat_data", s_out_data, 32'h40400000);
    chk("sat_count", 32'(s_out_count), 32'd3);
    take_result("six", 32'h40400000, 16'd6);
    chk("sat_idle", 32'(s_dbg_state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
